// File: rtl/adder_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
//   BYTE_W  : width of one adder slice
//   state_t : sequencer states IDLE -> RUN -> DONE
package adder_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder (purely combinational).
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^N
//   cout : carry out of the top bit
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic v_carry;
    v_carry = cin;
    sum     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]  = a[i] ^ b[i] ^ v_carry;
      v_carry = (a[i] & b[i]) | (v_carry & (a[i] ^ b[i]));
    end
    cout = v_carry;
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract built from one 8-bit adder used once per cycle, LSB
// byte first, with the inter-byte carry held in a register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   op_a, op_b, sub      : operands and op select (1 = op_a - op_b)
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   result               : sum/difference modulo 2^(8*WORDS)
//   carry_out            : final carry (subtract: 1 = no borrow)
//   overflow             : two's-complement signed overflow
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*WORDS-1:0]    op_a,
  input  logic [8*WORDS-1:0]    op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*WORDS-1:0]    result,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int W     = BYTE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;       // already inverted for subtract
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum;
  logic              w_cout;

  always_comb begin
    w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
    w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];
  end

  adder_n #(.N(BYTE_W)) u_adder (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            // Subtract as A + ~B + 1: invert B once here, seed carry with 1.
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result[r_idx*BYTE_W +: BYTE_W] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_cout;
            // Sign bits of A and B' agree but the result sign differs.
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum[BYTE_W-1] != r_a[W-1]);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Reference: plain wide arithmetic and signed range test.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint sa, sb, sr;
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = W'(ua - ub);
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = W'(ua + ub);
      c  = ((ua + ub) >= (longint'(1) << W));
      sr = sa + sb;
    end
    v = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; optionally hold out_ready low for 'hold' cycles in
  // DONE while offering junk operands that must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold);
    logic [W-1:0] er;
    logic ec, ev;
    int k;
    model(a, b, s, er, ec, ev);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    check("in_ready_pre_accept", W'(in_ready), W'(1));
    @(posedge clk);                         // accept edge
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
    k = 0;                                  // edges elapsed since accept
    while (!out_valid && k < 40) begin @(negedge clk); k++; end
    check("latency", W'(k), W'(WORDS));
    check("result", result, er);
    check("carry_out", W'(carry_out), W'(ec));
    check("overflow", W'(overflow), W'(ev));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_result", result, er);
      check("bp_flags", W'({carry_out, overflow}), W'({ec, ev}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);                         // handshake edge
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", W'(out_valid), W'(0));
    check("post_in_ready", W'(in_ready), W'(1));
    check("persist_result", result, er);
  endtask

  initial begin
    logic [W-1:0] qa[8], qb[8], qr[8];
    logic         qs[8], qc[8], qv[8];
    int issued, done, cyc, last_acc, budget;
    logic acc_now;

    // Reset state
    #12;
    check("rst_result", result, '0);
    check("rst_flags", W'({out_valid, carry_out, overflow}), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    // Explicit spec values for two of them
    check("sub_wrap_value", result, 32'h7FFF_FFFF);
    check("sub_wrap_flags", W'({carry_out, overflow}), W'(2'b11));

    // Backpressure
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 10);

    // Reset two cycles into RUN
    @(negedge clk);
    op_a = 32'hAAAA_5555; op_b = 32'h1234_4321; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_result", result, '0);
    check("midrst_flags", W'({out_valid, carry_out, overflow}), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    check("after_rst_value", result, 32'h2345_6789);

    // Random single operations
    for (int i = 0; i < 10; i++)
      run_op($urandom, $urandom, 1'($urandom), 0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 8; i++) begin
      qa[i] = $urandom; qb[i] = $urandom; qs[i] = 1'($urandom);
      model(qa[i], qb[i], qs[i], qr[i], qc[i], qv[i]);
    end
    issued = 0; done = 0; cyc = 0; last_acc = 0; budget = 0;
    out_ready = 1'b1;
    while (done < 8 && budget < 200) begin
      @(negedge clk);
      budget++;
      if (out_valid) begin
        check("b2b_result", result, qr[done]);
        check("b2b_flags", W'({carry_out, overflow}), W'({qc[done], qv[done]}));
        done++;
      end
      acc_now = 1'b0;
      if (issued < 8) begin
        in_valid = 1'b1;
        op_a = qa[issued]; op_b = qb[issued]; sub = qs[issued];
        acc_now = in_ready;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      cyc++;
      if (acc_now) begin
        if (issued > 0) check("b2b_spacing", W'(cyc - last_acc), W'(WORDS + 2));
        last_acc = cyc;
        issued++;
      end
    end
    check("b2b_completed", W'(done), W'(8));
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Sequencer that performs a wide (8×WORDS-bit) add or subtract by time-multiplexing one 8-bit ripple-carry adder over successive bytes, LSB first, holding the inter-byte carry in a register. It sits between an operand producer and a result consumer using valid/ready handshakes on both sides. Area is traded for latency: one byte per cycle, with a fixed, data-independent cycle count.

## Interface
- WORDS, 4, number of 8-bit slices in an operand; legal range 1..16
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands; high only in IDLE
- op_a  in  8*WORDS  first operand, sampled on accept
- op_b  in  8*WORDS  second operand, sampled on accept
- sub  in  1  1 = op_a − op_b, 0 = op_a + op_b; sampled on accept
- out_valid  out  1  result holds a completed operation
- out_ready  in  1  consumer accepts the result
- result  out  8*WORDS  sum or difference, modulo 2^(8*WORDS)
- carry_out  out  1  final carry; for subtract, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid: latch op_a and (sub ? ~op_b : op_b); set carry register = sub; set byte index = 0; go to RUN.
- **RUN**, one byte per cycle:
  - Adder inputs are latched byte[idx] of A, latched byte[idx] of B′, and the carry register.
  - Write the sum into result byte[idx]; carry register <= cout; idx++.
  - When idx == WORDS−1, go to DONE.
- **Arithmetic**
  - Subtract is A + ~B + 1.
  - carry_out = final cout.
  - overflow = (A_msb == B′_msb) && (result_msb != A_msb), where B′ is the post-inversion operand.
- **DONE**
  - out_valid = 1.
  - result, carry_out and overflow are held stable until out_ready.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
- **Ignored inputs**
  - in_valid, op_a, op_b and sub are ignored outside IDLE.
  - out_ready is ignored outside DONE.
- **Result persistence:** result, carry_out and overflow keep their last value after the handshake until the next RUN overwrites them. result bytes above the current idx are undefined during RUN.
- **Index register:** max($clog2(WORDS), 1) bits. WORDS = 1 is legal; RUN then lasts one cycle.
- **Reset:** rst_n low at any time, including mid-RUN or in DONE:
  - Aborts the operation; state goes to IDLE.
  - result, carry_out, overflow and out_valid go to 0.
  - Internal operand, carry and index registers go to 0.
  - in_ready reads 1, since it is a decode of IDLE.

## Timing
- Accept at edge T (in_valid && in_ready). RUN occupies edges T+1 .. T+WORDS. out_valid rises after edge T+WORDS, i.e. visible in the cycle following the last RUN edge.
- For WORDS = 4: accept at cycle 0, out_valid high from cycle 5.
- Throughput is one operation per WORDS+2 cycles with out_ready held high. There is no accept in the cycle DONE exits: in_ready rises the cycle after the out_ready handshake.
- in_ready and out_valid are Moore outputs (state decode only). There is no combinational path from in_valid or out_ready to any output.
- The adder is the only combinational path in RUN: 8-bit ripple plus the register setup.

## Structure
- Shared package adder_seq_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - localparam BYTE_W = 8.
- One sub-module: the team's existing 8-bit ripple-carry adder adder_n (a, b, cin, sum, cout), instantiated once.
- The top contains the FSM, operand registers, carry register, index counter, result register and flag logic.

## Test plan
All scenarios use WORDS = 4.
- **Add, byte carry:** add 0x000000FF + 0x00000001 → result 0x00000100, carry_out 0, overflow 0. out_valid first high 5 cycles after accept.
- **Add, full carry-out:** add 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_out 1, overflow 0. Then add 0x7FFFFFFF + 0x00000001 → result 0x80000000, carry_out 0, overflow 1.
- **Subtract:** 0x00000005 − 0x00000007 → result 0xFFFFFFFE, carry_out 0, overflow 0. Then 0x80000000 − 0x00000001 → result 0x7FFFFFFF, carry_out 1, overflow 1.
- **Backpressure:** hold out_ready low for 10 cycles in DONE while pulsing in_valid with new operands → result, carry_out and flags stay stable; in_ready stays 0; the new operands are not taken. After release, in_ready returns 1 one cycle after the handshake.
- **Reset mid-operation:** assert rst_n low two cycles into RUN → out_valid, result, carry_out and overflow are 0, and in_ready is 1. After release, add 0x12345678 + 0x11111111 → result 0x23456789.
- **Back-to-back:** hold in_valid and out_ready high continuously → accepts are spaced exactly WORDS+2 = 6 cycles apart, and each result matches its reference sum.
